// File: rtl/btn_event.sv
// Button event decoder: turns a debounced button level into press, release,
// long-press and auto-repeat pulses plus a held level and a press counter.
module btn_event #(
  parameter int unsigned LONG_TICKS   = 1000,
  parameter int unsigned REPEAT_TICKS = 200
) (
  input  logic       msclk,
  input  logic       rst_n,
  input  logic       cleanbtn,
  output logic       press,
  output logic       release_pulse,
  output logic       long_press,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;

  localparam logic [15:0] LONG_LAST   = 16'(LONG_TICKS - 1);
  localparam logic [15:0] REPEAT_LAST = 16'(REPEAT_TICKS - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        btn_q, btn_d;
  logic        press_q, press_d;
  logic        release_q, release_d;
  logic        long_q, long_d;
  logic        repeat_q, repeat_d;
  logic        held_q, held_d;
  logic [7:0]  count_q, count_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    btn_d     = cleanbtn;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    count_d   = count_q;

    case (state_q)
      IDLE: begin
        // Rising edge only: a level held since before reset never counts.
        if (cleanbtn && !btn_q) begin
          state_d = PRESSED;
          cnt_d   = 16'd0;
          press_d = 1'b1;
          count_d = count_q + 8'd1;
        end
      end
      PRESSED: begin
        if (!cleanbtn) begin
          state_d   = IDLE;
          cnt_d     = 16'd0;
          release_d = 1'b1;
        end else if (cnt_q == LONG_LAST) begin
          state_d = LONG;
          cnt_d   = 16'd0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      LONG: begin
        if (!cleanbtn) begin
          state_d   = IDLE;
          cnt_d     = 16'd0;
          release_d = 1'b1;
        end else if (cnt_q == REPEAT_LAST) begin
          cnt_d    = 16'd0;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
    endcase

    held_d = (state_d != IDLE);
  end

  always_ff @(posedge msclk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      btn_q     <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      btn_q     <= btn_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
      count_q   <= count_d;
    end
  end

  assign press         = press_q;
  assign release_pulse = release_q;
  assign long_press    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = held_q;
  assign press_count   = count_q;

endmodule

// File: tb/tb_btn_event.sv
// Bench for btn_event: directed scenarios plus random button activity, all
// checked every cycle against a timeline model (edges elapsed since press).
module tb_btn_event;

  localparam int L = 8;
  localparam int R = 3;

  logic       msclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cleanbtn = 1'b0;
  logic       press, release_pulse, long_press, repeat_pulse, held;
  logic [7:0] press_count;

  btn_event #(.LONG_TICKS(L), .REPEAT_TICKS(R)) dut (
    .msclk(msclk), .rst_n(rst_n), .cleanbtn(cleanbtn),
    .press(press), .release_pulse(release_pulse), .long_press(long_press),
    .repeat_pulse(repeat_pulse), .held(held), .press_count(press_count)
  );

  always #5 msclk = ~msclk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int   now = 0;
  bit   m_active = 0;
  bit   m_prev = 1;
  int   m_t0 = 0;
  int   m_count = 0;
  bit   e_press, e_rel, e_long, e_rep;

  // Pulses observed since the last clear, for scenario-level checks
  int   n_press, n_rel, n_long, n_rep, held_cycles;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, now, obs, exp);
    end
  endtask

  task automatic clr_obs();
    n_press = 0; n_rel = 0; n_long = 0; n_rep = 0; held_cycles = 0;
  endtask

  task automatic step(input bit c, input bit rst = 1'b1);
    int d;
    cleanbtn = c;
    rst_n    = rst;
    @(posedge msclk);
    now++;
    e_press = 0; e_rel = 0; e_long = 0; e_rep = 0;
    if (!rst) begin
      m_active = 0; m_prev = 1; m_count = 0;
    end else begin
      if (m_active) begin
        if (!c) begin
          e_rel = 1; m_active = 0;
        end else begin
          d = now - m_t0;
          if (d == L) e_long = 1;
          else if (d > L && (d - L) % R == 0) e_rep = 1;
        end
      end else if (c && !m_prev) begin
        e_press = 1; m_active = 1; m_t0 = now; m_count = (m_count + 1) % 256;
      end
      m_prev = c;
    end
    #1;
    chk("press", int'(press), int'(e_press));
    chk("release", int'(release_pulse), int'(e_rel));
    chk("long_press", int'(long_press), int'(e_long));
    chk("repeat", int'(repeat_pulse), int'(e_rep));
    chk("held", int'(held), int'(m_active));
    chk("press_count", int'(press_count), m_count);
    chk("one_hot_pulses", int'($countones({press, release_pulse, long_press, repeat_pulse}) <= 1), 1);
    n_press += int'(press); n_rel += int'(release_pulse);
    n_long += int'(long_press); n_rep += int'(repeat_pulse);
    held_cycles += int'(held);
  endtask

  initial begin
    int lvl, len;

    // Reset state
    step(0, 0); step(0, 0);
    chk("reset_count", int'(press_count), 0);
    step(0);

    // Short press: 5 cycles high
    clr_obs();
    for (int i = 0; i < 5; i++) step(1);
    step(0); step(0);
    chk("short_press_n", n_press, 1);
    chk("short_release_n", n_rel, 1);
    chk("short_long_n", n_long, 0);
    chk("short_held_cycles", held_cycles, 5);
    chk("short_count", int'(press_count), 1);

    // Long hold: 20 cycles high
    clr_obs();
    for (int i = 0; i < 20; i++) step(1);
    step(0); step(0);
    chk("long_long_n", n_long, 1);
    chk("long_repeat_n", n_rep, 3);
    chk("long_release_n", n_rel, 1);
    chk("long_held_cycles", held_cycles, 20);

    // Race: button drops exactly at the long_press edge
    clr_obs();
    for (int i = 0; i < L; i++) step(1);
    step(0); step(0);
    chk("race_long_n", n_long, 0);
    chk("race_release_n", n_rel, 1);

    // Reset with button held through it
    step(1); step(1);
    step(1, 0); step(1, 0);
    clr_obs();
    step(1); step(1); step(1);
    chk("rst_held_press_n", n_press, 0);
    chk("rst_held_rel_n", n_rel, 0);
    step(0); step(1);
    chk("rst_held_count", int'(press_count), 1);
    step(0);

    // Wrap of press_count
    step(0, 0); step(0);
    for (int i = 0; i < 256; i++) begin step(1); step(0); end
    chk("wrap_256", int'(press_count), 0);
    step(1); step(0);
    chk("wrap_257", int'(press_count), 1);

    // Back-to-back 1,0,1
    clr_obs();
    step(1); step(0); step(1);
    chk("b2b_press_n", n_press, 2);
    chk("b2b_release_n", n_rel, 1);
    chk("b2b_count", int'(press_count), 3);
    step(0);

    // Random activity with occasional reset
    for (int k = 0; k < 300; k++) begin
      lvl = int'($urandom_range(0, 1));
      len = int'($urandom_range(1, 22));
      if ($urandom_range(0, 39) == 0) begin
        step(bit'(lvl), 0);
        len = len - 1;
      end
      for (int i = 0; i < len; i++) step(bit'(lvl));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
